ring_phase_monitor: RTL and testbench

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

---
 rtl/ring_phase_monitor.sv | 151 +++++++++++++++
 tb/tb_ring_phase_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : ring_phase_monitor
//  Purpose  : Watches a 4-bit one-hot ring counter. It locks onto the first
//             valid code, then tracks phase and counts whole revolutions.
//             Any illegal step sends it to a sticky ERROR state that only
//             clr_err releases.
//  Options  : RING_PHASE_HOLD_EN - when defined, a repeated code (count ==
//             prev) while LOCKED is tolerated instead of flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module ring_phase_monitor #(
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       count,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_pulse
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    localparam logic [3:0] c_code0 = 4'b0001;
    localparam logic [3:0] c_code3 = 4'b1000;

    state_t             r_state;
    logic [3:0]         r_prev;
    logic [1:0]         r_phase;
    logic [REV_W-1:0]   r_rev;
    logic               r_pulse;
    logic               r_locked;
    logic               r_err;

    state_t             w_state_nxt;
    logic [3:0]         w_prev_nxt;
    logic [1:0]         w_phase_nxt;
    logic [REV_W-1:0]   w_rev_nxt;
    logic               w_pulse_nxt;

    logic               w_onehot;
    logic [1:0]         w_index;
    logic [3:0]         w_expect;
    logic               w_hold_ok;

    // Decode the incoming code: one-hot test, bit index, and legal successor
    always_comb begin
        w_onehot = 1'b0;
        w_index  = 2'd0;
        case (count)
            4'b0001: begin w_onehot = 1'b1; w_index = 2'd0; end
            4'b0010: begin w_onehot = 1'b1; w_index = 2'd1; end
            4'b0100: begin w_onehot = 1'b1; w_index = 2'd2; end
            4'b1000: begin w_onehot = 1'b1; w_index = 2'd3; end
            default: begin w_onehot = 1'b0; w_index = 2'd0; end
        endcase
        w_expect = {r_prev[2:0], r_prev[3]};
`ifdef RING_PHASE_HOLD_EN
        w_hold_ok = (count == r_prev);
`else
        w_hold_ok = 1'b0;
`endif
    end

    // Next-state and next-output logic; everything holds unless a rule fires
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_phase_nxt = r_phase;
        w_rev_nxt   = r_rev;
        w_pulse_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_onehot) begin
                    w_state_nxt = S_LOCKED;
                    w_prev_nxt  = count;
                    w_phase_nxt = w_index;
                    w_rev_nxt   = '0;
                end
            end
            S_LOCKED: begin
                if (en) begin
                    if (count == w_expect) begin
                        w_prev_nxt  = count;
                        w_phase_nxt = w_index;
                        // Completing 1000 -> 0001 closes one revolution
                        if (r_prev == c_code3 && count == c_code0) begin
                            w_rev_nxt   = r_rev + REV_W'(1);
                            w_pulse_nxt = 1'b1;
                        end
                    end else if (w_hold_ok) begin
                        w_state_nxt = S_LOCKED;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                // Sticky: count and en are ignored, only clr_err leaves
                if (clr_err) begin
                    w_state_nxt = S_IDLE;
                    w_rev_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_prev_nxt  = c_code0;
                w_phase_nxt = 2'd0;
                w_rev_nxt   = '0;
            end
        endcase
    end

    // State register and registered outputs; rst is active-low, synchronous
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_prev   <= c_code0;
            r_phase  <= 2'd0;
            r_rev    <= '0;
            r_pulse  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_prev   <= w_prev_nxt;
            r_phase  <= w_phase_nxt;
            r_rev    <= w_rev_nxt;
            r_pulse  <= w_pulse_nxt;
            r_locked <= (w_state_nxt == S_LOCKED);
            r_err    <= (w_state_nxt == S_ERROR);
        end
    end

    assign phase     = r_phase;
    assign locked    = r_locked;
    assign err       = r_err;
    assign rev_count = r_rev;
    assign rev_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_phase_monitor
//  Purpose  : Directed self-checking bench for ring_phase_monitor. A second
//             instance with REV_W=2 shares the stimulus to exercise wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_phase_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] count;
    logic       clr_err;

    logic [1:0] phase,  phase2;
    logic       locked, locked2;
    logic       err,    err2;
    logic [7:0] rev_count;
    logic [1:0] rev_count2;
    logic       rev_pulse, rev_pulse2;

    int n_checks = 0;
    int n_pass   = 0;

    ring_phase_monitor #(.REV_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .count(count), .clr_err(clr_err),
        .phase(phase), .locked(locked), .err(err),
        .rev_count(rev_count), .rev_pulse(rev_pulse)
    );

    ring_phase_monitor #(.REV_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .count(count), .clr_err(clr_err),
        .phase(phase2), .locked(locked2), .err(err2),
        .rev_count(rev_count2), .rev_pulse(rev_pulse2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] c);
        en    = e;
        count = c;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; count = 4'b0000; clr_err = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; count = 4'b0001; clr_err = 1'b0;
        step();
        n_checks++;
        if ({phase, locked, err, rev_count, rev_pulse} !== 13'd0)
            $display("FAIL reset_outputs: got ph=%0d lk=%0b er=%0b rc=%0d rp=%0b want all 0",
                     phase, locked, err, rev_count, rev_pulse);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_lock_track();
        logic [3:0] codes [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] phs   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, codes[i]);
            n_checks++;
            if (phase !== phs[i] || locked !== 1'b1 || err !== 1'b0)
                $display("FAIL track_%0d: got ph=%0d lk=%0b er=%0b want ph=%0d lk=1 er=0",
                         i, phase, locked, err, phs[i]);
            else n_pass++;
            n_checks++;
            if (rev_pulse !== (i == 4))
                $display("FAIL track_pulse_%0d: got %0b want %0b", i, rev_pulse, (i == 4));
            else n_pass++;
        end
        n_checks++;
        if (rev_count !== 8'd1)
            $display("FAIL track_revcount: got %0d want 1", rev_count);
        else n_pass++;
        // en=0 holds everything; pulse must drop
        drive(1'b0, 4'b1000);
        n_checks++;
        if (rev_pulse !== 1'b0 || rev_count !== 8'd1 || locked !== 1'b1 || phase !== 2'd0)
            $display("FAIL track_en0_hold: got rp=%0b rc=%0d lk=%0b ph=%0d want rp=0 rc=1 lk=1 ph=0",
                     rev_pulse, rev_count, locked, phase);
        else n_pass++;
    endtask

    task automatic test_idle_tolerance();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 3) ? 4'b0110 : 4'b0000);
            n_checks++;
            if (err !== 1'b0 || locked !== 1'b0)
                $display("FAIL idle_nonhot_%0d: got er=%0b lk=%0b want 0 0", i, err, locked);
            else n_pass++;
        end
        drive(1'b1, 4'b0100);
        n_checks++;
        if (locked !== 1'b1 || phase !== 2'd2 || err !== 1'b0)
            $display("FAIL idle_lock_0100: got lk=%0b ph=%0d er=%0b want 1 2 0", locked, phase, err);
        else n_pass++;
    endtask

    task automatic test_skip_error();
        do_reset();
        drive(1'b1, 4'b1000);
        drive(1'b1, 4'b0001);   // rev_count = 1
        drive(1'b1, 4'b0010);   // phase = 1
        drive(1'b1, 4'b1000);   // skip
        n_checks++;
        if (err !== 1'b1 || locked !== 1'b0 || phase !== 2'd1 || rev_count !== 8'd1)
            $display("FAIL skip_error: got er=%0b lk=%0b ph=%0d rc=%0d want 1 0 1 1",
                     err, locked, phase, rev_count);
        else n_pass++;
        drive(1'b1, 4'b0100);   // ignored in ERROR
        n_checks++;
        if (err !== 1'b1 || phase !== 2'd1 || rev_count !== 8'd1)
            $display("FAIL error_frozen: got er=%0b ph=%0d rc=%0d want 1 1 1", err, phase, rev_count);
        else n_pass++;
        // clr_err wins over a valid lock code in the same cycle
        clr_err = 1'b1;
        drive(1'b1, 4'b0001);
        clr_err = 1'b0;
        n_checks++;
        if (err !== 1'b0 || locked !== 1'b0 || rev_count !== 8'd0)
            $display("FAIL clr_err: got er=%0b lk=%0b rc=%0d want 0 0 0", err, locked, rev_count);
        else n_pass++;
        drive(1'b1, 4'b0010);
        n_checks++;
        if (locked !== 1'b1 || phase !== 2'd1)
            $display("FAIL relock_after_clr: got lk=%0b ph=%0d want 1 1", locked, phase);
        else n_pass++;
        // clr_err ignored while LOCKED
        clr_err = 1'b1;
        drive(1'b1, 4'b0100);
        clr_err = 1'b0;
        n_checks++;
        if (locked !== 1'b1 || phase !== 2'd2 || err !== 1'b0)
            $display("FAIL clr_in_locked: got lk=%0b ph=%0d er=%0b want 1 2 0", locked, phase, err);
        else n_pass++;
        // reverse step
        drive(1'b1, 4'b0010);
        n_checks++;
        if (err !== 1'b1 || phase !== 2'd2)
            $display("FAIL reverse_error: got er=%0b ph=%0d want 1 2", err, phase);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 4'b0100);
        drive(1'b1, 4'b0100);
`ifdef RING_PHASE_HOLD_EN
        n_checks++;
        if (err !== 1'b0 || locked !== 1'b1 || phase !== 2'd2 || rev_pulse !== 1'b0)
            $display("FAIL hold_allowed: got er=%0b lk=%0b ph=%0d rp=%0b want 0 1 2 0",
                     err, locked, phase, rev_pulse);
        else n_pass++;
`else
        n_checks++;
        if (err !== 1'b1 || locked !== 1'b0 || phase !== 2'd2)
            $display("FAIL hold_error: got er=%0b lk=%0b ph=%0d want 1 0 2", err, locked, phase);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        logic [1:0] exp2 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int pulses = 0;
        do_reset();
        drive(1'b1, 4'b0001);
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, 4'b0010); pulses += rev_pulse2;
            drive(1'b1, 4'b0100); pulses += rev_pulse2;
            drive(1'b1, 4'b1000); pulses += rev_pulse2;
            drive(1'b1, 4'b0001); pulses += rev_pulse2;
            n_checks++;
            if (rev_count2 !== exp2[r] || err2 !== 1'b0 || rev_pulse2 !== 1'b1)
                $display("FAIL wrap2_rev%0d: got rc=%0d er=%0b rp=%0b want rc=%0d er=0 rp=1",
                         r, rev_count2, err2, rev_pulse2, exp2[r]);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 4)
            $display("FAIL wrap2_pulses: got %0d want 4", pulses);
        else n_pass++;
        // Carry the 8-bit instance on to 256 revolutions total
        for (int r = 4; r < 256; r++) begin
            drive(1'b1, 4'b0010);
            drive(1'b1, 4'b0100);
            drive(1'b1, 4'b1000);
            drive(1'b1, 4'b0001);
        end
        n_checks++;
        if (rev_count !== 8'd0 || rev_pulse !== 1'b1 || err !== 1'b0 || locked !== 1'b1)
            $display("FAIL wrap8: got rc=%0d rp=%0b er=%0b lk=%0b want 0 1 0 1",
                     rev_count, rev_pulse, err, locked);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 4'b0001);
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 4'b0010);
            drive(1'b1, 4'b0100);
            drive(1'b1, 4'b1000);
            drive(1'b1, 4'b0001);
        end
        n_checks++;
        if (rev_count !== 8'd3)
            $display("FAIL midrst_pre: got rc=%0d want 3", rev_count);
        else n_pass++;
        rst = 1'b0;
        drive(1'b1, 4'b0010);
        rst = 1'b1;
        n_checks++;
        if ({phase, locked, err, rev_count, rev_pulse} !== 13'd0)
            $display("FAIL midrst_outputs: got ph=%0d lk=%0b er=%0b rc=%0d rp=%0b want all 0",
                     phase, locked, err, rev_count, rev_pulse);
        else n_pass++;
        drive(1'b1, 4'b0001);
        n_checks++;
        if (locked !== 1'b1 || phase !== 2'd0 || rev_count !== 8'd0 || rev_pulse !== 1'b0)
            $display("FAIL midrst_relock: got lk=%0b ph=%0d rc=%0d rp=%0b want 1 0 0 0",
                     locked, phase, rev_count, rev_pulse);
        else n_pass++;
        // Reset out of ERROR as well
        drive(1'b1, 4'b0100);
        rst = 1'b0;
        drive(1'b0, 4'b0000);
        rst = 1'b1;
        n_checks++;
        if (err !== 1'b0 || locked !== 1'b0 || phase !== 2'd0)
            $display("FAIL errrst: got er=%0b lk=%0b ph=%0d want 0 0 0", err, locked, phase);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; count = 4'b0000; clr_err = 1'b0;
        test_reset();
        test_lock_track();
        test_idle_tolerance();
        test_skip_error();
        test_hold();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
